march_bist_ram: RTL and testbench

Parametrised RAM-with-BIST block, successor to the fixed 8-bit/1K-deep sub-BIST RAM. It wraps a synchronous dual-port RAM and a March-test controller selectable between March C- and MATS+. It captures the first failing address and a saturating fail count, and keeps a sticky first-run failure flag. It sits between the board I/O (button, status LEDs) and the user datapath. Functional access is blocked while a test runs.

---
 rtl/march_bist_pkg.sv | 61 ++++++
 rtl/bist_ram_core.sv | 35 +++
 rtl/march_bist_ram.sv | 159 +++++++++++++++
 tb/tb_march_bist_ram.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/march_bist_pkg.sv
// Shared types and March element tables for the RAM BIST sequencer.
// Each element is described by its direction, its op count and its read/write background values.
package march_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic down;     // descending address order
    logic two_ops;  // read followed by write at each address
    logic has_rd;   // first op at each address is a read
    logic rd_val;   // expected background of the read
    logic wr_val;   // background written
  } elem_t;

  localparam logic ALG_MARCH_C = 1'b0;
  localparam logic ALG_MATS    = 1'b1;

  localparam int MARCH_C_ELEMS = 6;
  localparam int MATS_ELEMS    = 3;
  localparam int ELEM_IDX_W    = 3;

  localparam elem_t EL_W0_UP   = '{down: 1'b0, two_ops: 1'b0, has_rd: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
  localparam elem_t EL_R0W1_UP = '{down: 1'b0, two_ops: 1'b1, has_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
  localparam elem_t EL_R1W0_UP = '{down: 1'b0, two_ops: 1'b1, has_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
  localparam elem_t EL_R0W1_DN = '{down: 1'b1, two_ops: 1'b1, has_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
  localparam elem_t EL_R1W0_DN = '{down: 1'b1, two_ops: 1'b1, has_rd: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
  localparam elem_t EL_R0_UP   = '{down: 1'b0, two_ops: 1'b0, has_rd: 1'b1, rd_val: 1'b0, wr_val: 1'b0};

  function automatic elem_t get_elem(input logic alg, input logic [ELEM_IDX_W-1:0] idx);
    elem_t e;
    e = EL_W0_UP;
    if (alg == ALG_MARCH_C) begin
      case (idx)
        3'd1:    e = EL_R0W1_UP;
        3'd2:    e = EL_R1W0_UP;
        3'd3:    e = EL_R0W1_DN;
        3'd4:    e = EL_R1W0_DN;
        3'd5:    e = EL_R0_UP;
        default: e = EL_W0_UP;
      endcase
    end else begin
      case (idx)
        3'd1:    e = EL_R0W1_UP;
        3'd2:    e = EL_R1W0_DN;
        default: e = EL_W0_UP;
      endcase
    end
    return e;
  endfunction

  function automatic logic elem_down(input logic alg, input logic [ELEM_IDX_W-1:0] idx);
    elem_t e;
    e = get_elem(alg, idx);
    return e.down;
  endfunction

  function automatic logic [ELEM_IDX_W-1:0] last_elem(input logic alg);
    return (alg == ALG_MATS) ? ELEM_IDX_W'(MATS_ELEMS - 1) : ELEM_IDX_W'(MARCH_C_ELEMS - 1);
  endfunction

endpackage

// File: rtl/bist_ram_core.sv
// Simple dual-port RAM (A write, B read), read-first, with a stuck-at-1 hook on bit 0.
// The fault is applied on the read path so both test and functional reads see it.
module bist_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              flt_en_i,
  input  logic [ADDR_W-1:0] flt_addr_i,
  output logic [DATA_W-1:0] rd_dat_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_dat_q;
  logic [DATA_W-1:0] flt_mask;

  assign flt_mask = DATA_W'(flt_en_i && (rd_addr_i == flt_addr_i));

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) rd_dat_q <= '0;
    else          rd_dat_q <= mem[rd_addr_i] | flt_mask;
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/march_bist_ram.sv
// RAM with March C- / MATS+ self-test: start edge detect, address sequencer,
// one-cycle-delayed compare and result/sticky-status registers.
module march_bist_ram
  import march_bist_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wrt_addrs,
  input  logic [ADDR_W-1:0] rd_addrs,
  input  logic [DATA_W-1:0] wrt_dat,
  input  logic              wrt_en,
  input  logic              button,
  input  logic              mode,
  input  logic              flt_en,
  input  logic [ADDR_W-1:0] flt_addr,
  output logic [DATA_W-1:0] rd_dat,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              failed_first_test,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [CNT_W-1:0]  fail_count
);

  state_t                state_q;
  logic                  alg_q, op_q, button_q, armed_q;
  logic                  busy_q, pass_q, fail_q, ffirst_q, first_done_q;
  logic [ELEM_IDX_W-1:0] elem_q;
  logic [ADDR_W-1:0]     addr_q, cmp_addr_q, fail_addr_q;
  logic [CNT_W-1:0]      fail_count_q;
  logic                  cmp_vld_q, exp_q;

  elem_t             cur_elem;
  logic              nxt_down, is_rd, op_last, addr_end, start, in_run, mismatch;
  logic [ADDR_W-1:0] addr_d;
  logic [CNT_W-1:0]  fail_count_d;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdat;

  assign cur_elem = get_elem(alg_q, elem_q);
  assign nxt_down = elem_down(alg_q, elem_q + ELEM_IDX_W'(1));
  assign in_run   = (state_q == RUN);
  assign is_rd    = cur_elem.has_rd && !op_q;
  assign op_last  = !cur_elem.two_ops || op_q;
  assign addr_end = cur_elem.down ? (addr_q == '0) : (addr_q == '1);
  assign addr_d   = cur_elem.down ? addr_q - 1'b1 : addr_q + 1'b1;
  // armed_q blocks a button already held high when reset is released
  assign start    = button && !button_q && armed_q;

  assign mismatch     = cmp_vld_q && (rd_dat != {DATA_W{exp_q}});
  assign fail_count_d = (fail_count_q == '1) ? fail_count_q : fail_count_q + 1'b1;

  assign ram_we    = busy_q ? (in_run && !is_rd) : wrt_en;
  assign ram_waddr = busy_q ? addr_q : wrt_addrs;
  assign ram_wdat  = busy_q ? {DATA_W{cur_elem.wr_val}} : wrt_dat;
  assign ram_raddr = in_run ? addr_q : rd_addrs;

  bist_ram_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk        (clk),
    .rst_n_i    (rst),
    .wr_en_i    (ram_we),
    .wr_addr_i  (ram_waddr),
    .wr_dat_i   (ram_wdat),
    .rd_addr_i  (ram_raddr),
    .flt_en_i   (flt_en),
    .flt_addr_i (flt_addr),
    .rd_dat_o   (rd_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      alg_q        <= 1'b0;
      elem_q       <= '0;
      addr_q       <= '0;
      op_q         <= 1'b0;
      button_q     <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      ffirst_q     <= 1'b0;
      first_done_q <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
      cmp_vld_q    <= 1'b0;
      exp_q        <= 1'b0;
      cmp_addr_q   <= '0;
    end else begin
      button_q  <= button;
      cmp_vld_q <= 1'b0;
      if (!button) armed_q <= 1'b1;
      // fail_count is still zero exactly until the first mismatch lands
      if (mismatch) begin
        if (fail_count_q == '0) fail_addr_q <= cmp_addr_q;
        fail_count_q <= fail_count_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= RUN;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_count_q <= '0;
            alg_q        <= mode;
            elem_q       <= '0;
            op_q         <= 1'b0;
            addr_q       <= elem_down(mode, '0) ? '1 : '0;
          end
        end
        RUN: begin
          cmp_vld_q  <= is_rd;
          exp_q      <= cur_elem.rd_val;
          cmp_addr_q <= addr_q;
          if (!op_last) begin
            op_q <= 1'b1;
          end else begin
            op_q <= 1'b0;
            if (!addr_end) begin
              addr_q <= addr_d;
            end else if (elem_q == last_elem(alg_q)) begin
              state_q <= DRAIN;
            end else begin
              elem_q <= elem_q + ELEM_IDX_W'(1);
              addr_q <= nxt_down ? '1 : '0;
            end
          end
        end
        DRAIN: state_q <= DONE;
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pass_q  <= (fail_count_q == '0);
          fail_q  <= (fail_count_q != '0);
          if (!first_done_q) begin
            ffirst_q     <= (fail_count_q != '0);
            first_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign pass              = pass_q;
  assign fail              = fail_q;
  assign failed_first_test = ffirst_q;
  assign fail_addr         = fail_addr_q;
  assign fail_count        = fail_count_q;

endmodule

// File: tb/tb_march_bist_ram.sv
// Scoreboard bench for march_bist_ram: a 16-word instance for the main tests and a
// 2-bit fail-counter instance for the saturation case.
module tb_march_bist_ram;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  typedef struct {
    bit sat;
    int cycles;
    int pass;
    int fail;
    int faddr;
    int fcnt;
    int ffirst;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] wrt_addrs = '0, rd_addrs = '0, flt_addr = '0, flt_addr_s = '0;
  logic [DW-1:0] wrt_dat = '0;
  logic          wrt_en = 1'b0, button = 1'b0, mode = 1'b0, flt_en = 1'b0, flt_en_s = 1'b0;

  logic [DW-1:0] rd_dat, rd_dat_s;
  logic          busy, pass, fail, ffirst, busy_s, pass_s, fail_s, ffirst_s;
  logic [AW-1:0] fail_addr, fail_addr_s;
  logic [7:0]    fail_count;
  logic [1:0]    fail_count_s;

  int n_checks = 0;
  int n_errors = 0;
  res_t sb_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] mdl [N];

  always #5 clk = ~clk;

  march_bist_ram #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wrt_addrs(wrt_addrs), .rd_addrs(rd_addrs), .wrt_dat(wrt_dat),
    .wrt_en(wrt_en), .button(button), .mode(mode), .flt_en(flt_en), .flt_addr(flt_addr),
    .rd_dat(rd_dat), .busy(busy), .pass(pass), .fail(fail), .failed_first_test(ffirst),
    .fail_addr(fail_addr), .fail_count(fail_count)
  );

  march_bist_ram #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .wrt_addrs(wrt_addrs), .rd_addrs(rd_addrs), .wrt_dat(wrt_dat),
    .wrt_en(wrt_en), .button(button), .mode(mode), .flt_en(flt_en_s), .flt_addr(flt_addr_s),
    .rd_dat(rd_dat_s), .busy(busy_s), .pass(pass_s), .fail(fail_s), .failed_first_test(ffirst_s),
    .fail_addr(fail_addr_s), .fail_count(fail_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  function automatic res_t mk(input bit sat, input int cyc, input int ps, input int fa,
                              input int fc, input int ff);
    res_t r;
    r.sat = sat; r.cycles = cyc; r.pass = ps; r.fail = !ps;
    r.faddr = fa; r.fcnt = fc; r.ffirst = ff;
    return r;
  endfunction

  // address issued by MATS+ at op index m (w0 up, r0/w1 up, r1/w0 down)
  function automatic logic [AW-1:0] mats_addr(input int m);
    int a;
    if (m < N)          a = m;
    else if (m < 3 * N) a = (m - N) / 2;
    else                a = N - 1 - (m - 3 * N) / 2;
    return AW'(a);
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_dat"}, rd_dat, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_ffirst"}, ffirst, 0);
    chk({tag, "_fail_addr"}, fail_addr, 0);
    chk({tag, "_fail_count"}, fail_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; button = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic func_cycle(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input bit rd, input logic [AW-1:0] ra);
    logic [DW-1:0] e;
    wrt_en = we; wrt_addrs = wa; wrt_dat = wd; rd_addrs = ra;
    if (rd) begin
      e = mdl[ra];
      if (flt_en && flt_addr == ra) e[0] = 1'b1;
      exp_rd_q.push_back(e);
    end
    if (we) mdl[wa] = wd;
    @(negedge clk);
    wrt_en = 1'b0;
    if (rd) chk($sformatf("func_rd@%0d", ra), rd_dat, exp_rd_q.pop_front());
  endtask

  task automatic run_test(input bit md, input bit noise, input res_t e, input bit use_sat,
                          input res_t es);
    res_t r;
    int   cycles;
    sb_q.push_back(e);
    if (use_sat) sb_q.push_back(es);
    mode = md; button = 1'b1;
    @(negedge clk);
    chk("start_latency", busy, 1);
    button = 1'b0;
    cycles = 0;
    while (busy && cycles < 3000) begin
      if (use_sat) flt_addr_s = mats_addr(cycles);
      if (noise) begin
        wrt_en = 1'b1;
        wrt_addrs = AW'($urandom_range(0, N - 1));
        wrt_dat = DW'($urandom_range(1, 255));
      end
      cycles++;
      @(negedge clk);
    end
    wrt_en = 1'b0;
    for (int a = 0; a < N; a++) mdl[a] = '0;
    while (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      if (!r.sat) begin
        chk("busy_cycles", cycles, r.cycles);
        chk("pass", pass, r.pass);
        chk("fail", fail, r.fail);
        chk("fail_addr", fail_addr, r.faddr);
        chk("fail_count", fail_count, r.fcnt);
        chk("failed_first", ffirst, r.ffirst);
      end else begin
        chk("sat_busy", busy_s, 0);
        chk("sat_fail", fail_s, r.fail);
        chk("sat_fail_addr", fail_addr_s, r.faddr);
        chk("sat_fail_count", fail_count_s, r.fcnt);
        chk("sat_failed_first", ffirst_s, r.ffirst);
      end
    end
  endtask

  initial begin
    res_t none;
    none = mk(1'b0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // functional path, including same-address write/read returning old data
    func_cycle(1'b1, 4'd10, 8'hFF, 1'b0, 4'd0);
    func_cycle(1'b1, 4'd3, 8'h3C, 1'b0, 4'd0);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd10);
    func_cycle(1'b1, 4'd3, 8'h55, 1'b1, 4'd3);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);

    run_test(1'b0, 1'b0, mk(1'b0, 10 * N + 2, 1, 0, 0, 0), 1'b0, none);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd10);

    do_reset();
    flt_en = 1'b1; flt_addr = 4'd5;
    run_test(1'b1, 1'b0, mk(1'b0, 5 * N + 2, 0, 5, 1, 1), 1'b0, none);

    do_reset();
    run_test(1'b0, 1'b0, mk(1'b0, 10 * N + 2, 0, 5, 3, 1), 1'b0, none);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd5);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
    flt_en = 1'b0;
    run_test(1'b0, 1'b1, mk(1'b0, 10 * N + 2, 1, 0, 0, 1), 1'b0, none);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
    func_cycle(1'b0, 4'd0, 8'h00, 1'b1, 4'd15);

    // asynchronous reset mid-RUN with the button held through release
    mode = 1'b0; button = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_run_busy", busy, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      chk("held_button_no_start", busy, 0);
    end
    button = 1'b0;
    @(negedge clk);
    run_test(1'b1, 1'b0, mk(1'b0, 5 * N + 2, 1, 0, 0, 0), 1'b0, none);

    // every r0 read in the saturating instance hits the injected fault
    do_reset();
    flt_en_s = 1'b1;
    run_test(1'b1, 1'b0, mk(1'b0, 5 * N + 2, 1, 0, 0, 0), 1'b1, mk(1'b1, 0, 0, 0, 3, 1));
    flt_en_s = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
